sys_bus_ctrl: RTL and testbench
===============================

// Module: sys_bus_ctrl
// PURPOSE
//  Parametrised memory-map controller between CPU16 and its slaves: sync RAM, sync ROM and a
//  pipelined-wishbone IO peripheral. Registers the read-data select to match 1-cycle sync memory
//  latency. Stretches IO cycles via cpu_hold until ack, with timeout. Flags unmapped/timed-out accesses.
// PARAMETERS
//  ADDR_W      16       CPU address width
//  DATA_W      16       CPU data width
//  RAM_BASE    16'h0000 RAM base, aligned to 2**RAM_AW
//  RAM_AW      12       RAM word-address width
//  ROM_BASE    16'hF000 ROM base, aligned to 2**ROM_AW
//  ROM_AW      12       ROM word-address width
//  IO_BASE     16'h2000 IO base, aligned to 2**IO_AW
//  IO_AW       8        IO address width
//  IO_DW       8        IO data width (<= DATA_W), zero-extended on read
//  IO_TIMEOUT  15       max IO cycles (REQ+WAIT) before forced completion, >= 2
// PORTS
//  clk       in   1       system clock, all state on rising edge
//  reset_n   in   1       asynchronous active-low reset
//  cpu_addr  in   ADDR_W  CPU address
//  cpu_dout  in   DATA_W  CPU write data
//  cpu_we    in   1       CPU write enable
//  cpu_din   out  DATA_W  read data to CPU
//  cpu_hold  out  1       freeze CPU (addr/dout/we held stable while high)
//  err_clr   in   1       clears bus_err
//  bus_err   out  1       sticky: unmapped access or IO timeout
//  err_addr  out  ADDR_W  address of first error since last clear
//  ram_we    out  1       RAM write strobe
//  ram_dout  in   DATA_W  RAM read data (1-cycle latency)
//  rom_dout  in   DATA_W  ROM read data (1-cycle latency)
//  io_stb    out  1       wishbone strobe (cyc == stb)
//  io_we     out  1       wishbone write
//  io_addr   out  IO_AW   registered IO address
//  io_wdata  out  IO_DW   registered IO write data
//  io_rdata  in   IO_DW   IO read data, valid with io_ack
//  io_stall  in   1       slave not accepting strobe
//  io_ack    in   1       slave completion
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, cpu_hold=0, io_stb=0, io_we=0, io_addr/io_wdata=0,
//   sel_q=NONE, rd_q=0, bus_err=0, err_addr=0, tmo count=0. Mid-transaction reset aborts immediately.
//  Decode (comb, on cpu_addr): hit = (addr >> AW) == (BASE >> AW). Priority RAM > ROM > IO > NONE.
//  sel_q <= decoded region on every edge where cpu_hold=0 (held while cpu_hold=1).
//  cpu_din = sel_q RAM: ram_dout; ROM: rom_dout; IO: {0, rd_q}; NONE: 0.
//  ram_we = cpu_we & ram_hit & ~cpu_hold. ROM writes are ignored, no error.
//  NONE hit with cpu_hold=0: bus_err set, read returns 0, write dropped, no hold.
//  IO FSM:
//   IDLE: io_hit -> cpu_hold=1 (comb); latch addr[IO_AW-1:0], dout[IO_DW-1:0], we; go REQ.
//   REQ : io_stb=1, cpu_hold=1. io_stall=0 at edge -> WAIT (stb drops). io_ack here is accepted.
//   WAIT: io_stb=0, cpu_hold=1. io_ack -> rd_q<=io_rdata (reads only), go DONE.
//   DONE: cpu_hold=0 for exactly 1 cycle; CPU completes access; next IDLE.
//         cpu_din = rd_q in the following cycle.
//   Timeout: count clears on IDLE->REQ and increments each REQ/WAIT cycle. On count==IO_TIMEOUT
//    without ack: rd_q<=all ones, bus_err set, go DONE. Ack on the same edge wins (no error).
//  io_ack in IDLE/DONE is ignored.
//  err_addr latched only when bus_err is 0 (first error). err_clr clears bus_err.
//   Clear and new error on the same edge: error wins.
//  IO latency, zero-wait slave: hold high 2 cycles (IDLE-detect, REQ) + WAIT until ack.
// TESTING
//  RAM write 0x0010<=16'hBEEF, read 0x0010 -> ram_we 1 cycle, cpu_din=16'hBEEF next cycle, hold 0.
//  ROM read 0xF003 then RAM read 0x0004 back-to-back -> cpu_din follows sel_q, no mix-up.
//  IO read 0x2001, slave stall 2 cycles, ack after 1 -> io_stb high 3 cycles,
//   io_addr=8'h01, hold released in DONE, cpu_din=16'h00A5 for io_rdata=8'hA5.
//  IO write 0x2004<=16'h1234, no ack -> stb/hold held, timeout after 15 cycles, bus_err=1,
//   err_addr=16'h2004, io_wdata=8'h34.
//  Read 0x5000 -> cpu_din=0, bus_err=1, err_addr=16'h5000; err_clr pulse -> bus_err=0.
//  reset_n low during WAIT -> io_stb/cpu_hold 0 asynchronously; state IDLE after release.

Source files
------------

// File: rtl/sys_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// sys_bus_ctrl_if : CPU16 bus, sync RAM/ROM read ports and pipelined-wishbone IO
// Rev 1.0
// ============================================================================
interface sys_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IO_AW  = 8,
  parameter int IO_DW  = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_hold;
  logic              err_clr;
  logic              bus_err;
  logic [ADDR_W-1:0] err_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] rom_dout;
  logic              io_stb;
  logic              io_we;
  logic [IO_AW-1:0]  io_addr;
  logic [IO_DW-1:0]  io_wdata;
  logic [IO_DW-1:0]  io_rdata;
  logic              io_stall;
  logic              io_ack;

  modport master (
    input  cpu_addr, cpu_dout, cpu_we, err_clr, ram_dout, rom_dout,
           io_rdata, io_stall, io_ack,
    output cpu_din, cpu_hold, bus_err, err_addr, ram_we,
           io_stb, io_we, io_addr, io_wdata
  );

  modport slave (
    output cpu_addr, cpu_dout, cpu_we, err_clr, ram_dout, rom_dout,
           io_rdata, io_stall, io_ack,
    input  cpu_din, cpu_hold, bus_err, err_addr, ram_we,
           io_stb, io_we, io_addr, io_wdata
  );
endinterface
`default_nettype wire

// File: rtl/sys_bus_ctrl.sv
`default_nettype none
// ============================================================================
// sys_bus_ctrl : CPU16 memory-map controller for sync RAM/ROM and a wishbone IO slave
// Rev 1.0
// ============================================================================
module sys_bus_ctrl #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] RAM_BASE   = 16'h0000,
  parameter int                RAM_AW     = 12,
  parameter logic [ADDR_W-1:0] ROM_BASE   = 16'hF000,
  parameter int                ROM_AW     = 12,
  parameter logic [ADDR_W-1:0] IO_BASE    = 16'h2000,
  parameter int                IO_AW      = 8,
  parameter int                IO_DW      = 8,
  parameter int                IO_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset_n,
  sys_bus_ctrl_if.master bus
);

  localparam int TMO_W = $clog2(IO_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IO_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_ROM  = 2'd2;
  localparam logic [1:0] SEL_IO   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [IO_DW-1:0] r_rd;
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic             r_io_we;
  logic [IO_AW-1:0] r_io_addr;
  logic [IO_DW-1:0] r_io_wdata;

  logic       w_ram_hit, w_rom_hit, w_io_hit, w_none_hit;
  logic [1:0] w_sel;
  logic       w_hold, w_busy, w_tmo_hit, w_tmo_err, w_err;

  assign w_ram_hit  = (bus.cpu_addr >> RAM_AW) == (RAM_BASE >> RAM_AW);
  assign w_rom_hit  = (bus.cpu_addr >> ROM_AW) == (ROM_BASE >> ROM_AW);
  assign w_io_hit   = (bus.cpu_addr >> IO_AW)  == (IO_BASE  >> IO_AW);
  assign w_none_hit = ~w_ram_hit & ~w_rom_hit & ~w_io_hit;

  always_comb begin
    w_sel = SEL_NONE;
    if (w_ram_hit)      w_sel = SEL_RAM;
    else if (w_rom_hit) w_sel = SEL_ROM;
    else if (w_io_hit)  w_sel = SEL_IO;
  end

  assign w_busy = (r_state == ST_REQ) | (r_state == ST_WAIT);
  // Gated by reset_n so the CPU is released at once while reset is held.
  assign w_hold = ((r_state == ST_IDLE) & (w_sel == SEL_IO) & reset_n) | w_busy;
  // Fires in the cycle that would bring the REQ+WAIT count to IO_TIMEOUT.
  assign w_tmo_hit = (r_tmo == TMO_LAST);
  assign w_tmo_err = w_busy & ~bus.io_ack & w_tmo_hit;
  assign w_err     = (w_none_hit & ~w_hold) | w_tmo_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_NONE;
      r_rd       <= '0;
      r_tmo      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_io_we    <= 1'b0;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
    end else begin
      if (!w_hold) r_sel <= w_sel;

      case (r_state)
        ST_IDLE: begin
          if (w_sel == SEL_IO) begin
            r_state    <= ST_REQ;
            r_tmo      <= '0;
            r_io_we    <= bus.cpu_we;
            r_io_addr  <= bus.cpu_addr[IO_AW-1:0];
            r_io_wdata <= bus.cpu_dout[IO_DW-1:0];
          end
        end
        ST_REQ, ST_WAIT: begin
          if (bus.io_ack) begin
            if (!r_io_we) r_rd <= bus.io_rdata;
            r_state <= ST_DONE;
          end else if (w_tmo_hit) begin
            r_rd    <= '1;
            r_state <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
            if ((r_state == ST_REQ) && !bus.io_stall) r_state <= ST_WAIT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_err) begin
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= bus.cpu_addr;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.cpu_din = '0;
    case (r_sel)
      SEL_RAM: bus.cpu_din = bus.ram_dout;
      SEL_ROM: bus.cpu_din = bus.rom_dout;
      SEL_IO:  bus.cpu_din[IO_DW-1:0] = r_rd;
      default: bus.cpu_din = '0;
    endcase
  end

  assign bus.cpu_hold = w_hold;
  assign bus.ram_we   = bus.cpu_we & w_ram_hit & ~w_hold;
  assign bus.io_stb   = (r_state == ST_REQ);
  assign bus.io_we    = r_io_we;
  assign bus.io_addr  = r_io_addr;
  assign bus.io_wdata = r_io_wdata;
  assign bus.bus_err  = r_err;
  assign bus.err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sys_bus_ctrl : bench for sys_bus_ctrl with RAM/ROM/IO slave models and a scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sys_bus_ctrl;

  localparam int T = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sys_bus_ctrl_if #(.ADDR_W(16), .DATA_W(16), .IO_AW(8), .IO_DW(8)) bus ();

  sys_bus_ctrl #(
    .ADDR_W(16), .DATA_W(16), .RAM_BASE(16'h0000), .RAM_AW(12),
    .ROM_BASE(16'hF000), .ROM_AW(12), .IO_BASE(16'h2000), .IO_AW(8),
    .IO_DW(8), .IO_TIMEOUT(T)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [15:0] rom_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Environment: sync RAM/ROM and a wishbone slave with scripted stall/ack delays.
  logic [15:0] ram_mem [4096];
  int slv_stall = 0;
  int slv_wait  = 0;
  bit slv_noack = 1'b0;
  int st_cnt = 0;
  int wt_cnt = 0;
  bit accepted = 1'b0;

  assign bus.io_stall = bus.io_stb && (st_cnt < slv_stall);
  assign bus.io_ack   = accepted && !slv_noack && (wt_cnt == slv_wait);

  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.cpu_addr[11:0]] <= bus.cpu_dout;
    bus.ram_dout <= ram_mem[bus.cpu_addr[11:0]];
    bus.rom_dout <= rom_val(bus.cpu_addr);
    if (!bus.cpu_hold) begin
      accepted <= 1'b0;
      st_cnt   <= 0;
      wt_cnt   <= 0;
    end else if (accepted) begin
      wt_cnt <= wt_cnt + 1;
    end else if (bus.io_stb) begin
      if (st_cnt < slv_stall) st_cnt <= st_cnt + 1;
      else begin
        accepted <= 1'b1;
        wt_cnt   <= 0;
      end
    end
  end

  // Reference model state
  logic [15:0] ram_model [int];
  bit          exp_err;
  logic [15:0] exp_eaddr;
  logic [7:0]  exp_rd;

  task automatic drive(input logic [15:0] a, input logic we, input logic [15:0] d, input logic clr);
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_we   = we;
    bus.cpu_dout = d;
    bus.err_clr  = clr;
    #1;
  endtask

  task automatic clear_err();
    drive(16'h0000, 1'b0, 16'h0000, 1'b1);
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_we = 1'b0; bus.cpu_dout = 16'h0000;
    bus.err_clr = 1'b0; bus.io_rdata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (bus.cpu_hold !== 1'b0) $display("FAIL reset_hold: got %b exp 0", bus.cpu_hold); else n_pass++;
    n_total++; if (bus.io_stb !== 1'b0) $display("FAIL reset_stb: got %b exp 0", bus.io_stb); else n_pass++;
    n_total++; if (bus.io_we !== 1'b0) $display("FAIL reset_io_we: got %b exp 0", bus.io_we); else n_pass++;
    n_total++; if (bus.io_addr !== 8'h00) $display("FAIL reset_io_addr: got %h exp 00", bus.io_addr); else n_pass++;
    n_total++; if (bus.io_wdata !== 8'h00) $display("FAIL reset_io_wdata: got %h exp 00", bus.io_wdata); else n_pass++;
    n_total++; if (bus.bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b exp 0", bus.bus_err); else n_pass++;
    n_total++; if (bus.err_addr !== 16'h0000) $display("FAIL reset_err_addr: got %h exp 0000", bus.err_addr); else n_pass++;
    n_total++; if (bus.cpu_din !== 16'h0000) $display("FAIL reset_cpu_din: got %h exp 0000", bus.cpu_din); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    exp_err = 1'b0; exp_eaddr = 16'h0000; exp_rd = 8'h00;
  endtask

  task automatic test_ram_rw();
    drive(16'h0010, 1'b1, 16'hBEEF, 1'b0);
    ram_model[16'h0010] = 16'hBEEF;
    n_total++; if (bus.ram_we !== 1'b1) $display("FAIL ram_we_write: got %b exp 1", bus.ram_we); else n_pass++;
    n_total++; if (bus.cpu_hold !== 1'b0) $display("FAIL ram_hold: got %b exp 0", bus.cpu_hold); else n_pass++;
    drive(16'h0010, 1'b0, 16'h0000, 1'b0);
    n_total++; if (bus.ram_we !== 1'b0) $display("FAIL ram_we_read: got %b exp 0", bus.ram_we); else n_pass++;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
    n_total++; if (bus.cpu_din !== 16'hBEEF) $display("FAIL ram_read: got %h exp BEEF", bus.cpu_din); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    v = 16'($urandom);
    drive(16'h0004, 1'b1, v, 1'b0);
    ram_model[16'h0004] = v;
    drive(16'hF003, 1'b1, 16'hDEAD, 1'b0);
    n_total++; if (bus.ram_we !== 1'b0) $display("FAIL rom_write_ram_we: got %b exp 0", bus.ram_we); else n_pass++;
    drive(16'h0004, 1'b0, 16'h0000, 1'b0);
    n_total++; if (bus.cpu_din !== rom_val(16'hF003)) $display("FAIL b2b_rom: got %h exp %h", bus.cpu_din, rom_val(16'hF003)); else n_pass++;
    drive(16'h0010, 1'b0, 16'h0000, 1'b0);
    n_total++; if (bus.cpu_din !== v) $display("FAIL b2b_ram: got %h exp %h", bus.cpu_din, v); else n_pass++;
    n_total++; if (bus.bus_err !== 1'b0) $display("FAIL rom_write_no_err: got %b exp 0", bus.bus_err); else n_pass++;
  endtask

  task automatic test_unmapped();
    drive(16'h5000, 1'b0, 16'h0000, 1'b0);
    n_total++; if (bus.cpu_hold !== 1'b0) $display("FAIL none_hold: got %b exp 0", bus.cpu_hold); else n_pass++;
    drive(16'h6000, 1'b1, 16'h1111, 1'b0);
    n_total++; if (bus.cpu_din !== 16'h0000) $display("FAIL none_din: got %h exp 0000", bus.cpu_din); else n_pass++;
    n_total++; if (bus.bus_err !== 1'b1) $display("FAIL none_err: got %b exp 1", bus.bus_err); else n_pass++;
    n_total++; if (bus.err_addr !== 16'h5000) $display("FAIL none_eaddr: got %h exp 5000", bus.err_addr); else n_pass++;
    drive(16'h0000, 1'b0, 16'h0000, 1'b1);
    n_total++; if (bus.err_addr !== 16'h5000) $display("FAIL first_err_kept: got %h exp 5000", bus.err_addr); else n_pass++;
    drive(16'h7000, 1'b0, 16'h0000, 1'b1);
    n_total++; if (bus.bus_err !== 1'b0) $display("FAIL err_clr: got %b exp 0", bus.bus_err); else n_pass++;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
    n_total++; if (bus.bus_err !== 1'b1) $display("FAIL clr_vs_err: got %b exp 1", bus.bus_err); else n_pass++;
    n_total++; if (bus.err_addr !== 16'h7000) $display("FAIL clr_vs_err_addr: got %h exp 7000", bus.err_addr); else n_pass++;
    exp_eaddr = 16'h7000;
    clear_err();
  endtask

  // One IO access with S stalled REQ cycles and W ack-less WAIT cycles.
  task automatic do_io(input logic [15:0] a, input logic we, input logic [15:0] d,
                       input int s, input int w, input bit noack, input logic [7:0] rdata);
    int hold_n, stb_n, need, exp_hold, exp_stb;
    bit tmo;
    slv_stall = s; slv_wait = w; slv_noack = noack; bus.io_rdata = rdata;
    drive(a, we, d, 1'b0);
    hold_n = 0; stb_n = 0;
    for (int k = 0; k < 60 && bus.cpu_hold; k++) begin
      hold_n++;
      if (bus.io_stb) begin
        stb_n++;
        if (stb_n == 1) begin
          n_total++; if (bus.io_addr !== a[7:0]) $display("FAIL io_addr: got %h exp %h", bus.io_addr, a[7:0]); else n_pass++;
          n_total++; if (bus.io_we !== we) $display("FAIL io_we: got %b exp %b", bus.io_we, we); else n_pass++;
          if (we) begin
            n_total++; if (bus.io_wdata !== d[7:0]) $display("FAIL io_wdata: got %h exp %h", bus.io_wdata, d[7:0]); else n_pass++;
          end
        end
      end
      @(negedge clk); #1;
    end
    need     = noack ? T + 1 : s + w + 2;
    tmo      = need > T;
    exp_hold = 1 + (tmo ? T : need);
    exp_stb  = (s + 1 < T) ? s + 1 : T;
    if (tmo) begin
      if (!exp_err) exp_eaddr = a;
      exp_err = 1'b1;
      exp_rd  = 8'hFF;
    end else if (!we) begin
      exp_rd = rdata;
    end
    n_total++; if (hold_n !== exp_hold) $display("FAIL io_hold_cycles @%h: got %0d exp %0d", a, hold_n, exp_hold); else n_pass++;
    n_total++; if (stb_n !== exp_stb) $display("FAIL io_stb_cycles @%h: got %0d exp %0d", a, stb_n, exp_stb); else n_pass++;
    n_total++; if (bus.bus_err !== exp_err) $display("FAIL io_bus_err @%h: got %b exp %b", a, bus.bus_err, exp_err); else n_pass++;
    n_total++; if (bus.err_addr !== exp_eaddr) $display("FAIL io_err_addr: got %h exp %h", bus.err_addr, exp_eaddr); else n_pass++;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
    n_total++; if (bus.cpu_din !== {8'h00, exp_rd}) $display("FAIL io_din @%h: got %h exp %h", a, bus.cpu_din, {8'h00, exp_rd}); else n_pass++;
    n_total++; if (bus.cpu_hold !== 1'b0) $display("FAIL io_idle_after: got %b exp 0", bus.cpu_hold); else n_pass++;
  endtask

  task automatic test_io_read();
    do_io(16'h2001, 1'b0, 16'h0000, 2, 1, 1'b0, 8'hA5);
  endtask

  task automatic test_io_timeout();
    do_io(16'h2004, 1'b1, 16'h1234, 100, 0, 1'b1, 8'h00);
    clear_err();
  endtask

  task automatic test_io_boundary();
    do_io(16'h20F0, 1'b0, 16'h0000, 5, 8, 1'b0, 8'h5C);
    do_io(16'h2033, 1'b0, 16'h0000, 5, 9, 1'b0, 8'h77);
    clear_err();
  endtask

  task automatic test_random_mem();
    bit          have_prev, prev_known;
    logic [15:0] prev_exp, a, d;
    logic        we, clr;
    int          kind;
    have_prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      d    = 16'($urandom);
      clr  = ($urandom_range(0, 7) == 0);
      if (kind <= 5)      a = 16'($urandom_range(0, 15));
      else if (kind <= 7) a = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
      else if (kind == 8) a = 16'h3000 | 16'($urandom_range(0, 16'h0FFF));
      else                a = 16'h2100 + 16'($urandom_range(0, 16'h0EFF));
      drive(a, we, d, clr);
      n_total++; if (bus.ram_we !== (kind <= 5 && we)) $display("FAIL rnd_ram_we @%h: got %b exp %b", a, bus.ram_we, (kind <= 5 && we)); else n_pass++;
      n_total++; if (bus.cpu_hold !== 1'b0) $display("FAIL rnd_hold @%h: got %b exp 0", a, bus.cpu_hold); else n_pass++;
      if (have_prev && prev_known) begin
        n_total++; if (bus.cpu_din !== prev_exp) $display("FAIL rnd_din: got %h exp %h", bus.cpu_din, prev_exp); else n_pass++;
      end
      n_total++; if (bus.bus_err !== exp_err) $display("FAIL rnd_err: got %b exp %b", bus.bus_err, exp_err); else n_pass++;
      n_total++; if (bus.err_addr !== exp_eaddr) $display("FAIL rnd_eaddr: got %h exp %h", bus.err_addr, exp_eaddr); else n_pass++;
      have_prev = 1'b1;
      prev_known = 1'b1;
      if (kind <= 5) begin
        if (we) begin
          prev_known = 1'b0;
          ram_model[int'(a)] = d;
        end else if (ram_model.exists(int'(a))) prev_exp = ram_model[int'(a)];
        else prev_known = 1'b0;
      end else if (kind <= 7) prev_exp = rom_val(a);
      else prev_exp = 16'h0000;
      if (kind >= 8) begin
        if (!exp_err) exp_eaddr = a;
        exp_err = 1'b1;
      end else if (clr) exp_err = 1'b0;
    end
    clear_err();
  endtask

  task automatic test_random_io();
    for (int i = 0; i < 8; i++)
      do_io(16'h2000 | 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 16'($urandom),
            $urandom_range(0, 6), $urandom_range(0, 8), ($urandom_range(0, 5) == 0), 8'($urandom));
    clear_err();
  endtask

  task automatic test_reset_in_wait();
    slv_stall = 0; slv_wait = 50; slv_noack = 1'b1;
    drive(16'h2010, 1'b0, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_total++; if ({bus.cpu_hold, bus.io_stb} !== 2'b10) $display("FAIL wait_state: got %b exp 10", {bus.cpu_hold, bus.io_stb}); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (bus.cpu_hold !== 1'b0) $display("FAIL async_hold: got %b exp 0", bus.cpu_hold); else n_pass++;
    n_total++; if (bus.io_stb !== 1'b0) $display("FAIL async_stb: got %b exp 0", bus.io_stb); else n_pass++;
    @(negedge clk);
    bus.cpu_addr = 16'h0000;
    reset_n = 1'b1;
    exp_err = 1'b0; exp_eaddr = 16'h0000; exp_rd = 8'h00;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
    n_total++; if ({bus.cpu_hold, bus.io_stb} !== 2'b00) $display("FAIL post_reset_idle: got %b exp 00", {bus.cpu_hold, bus.io_stb}); else n_pass++;
    n_total++; if (bus.bus_err !== 1'b0) $display("FAIL post_reset_err: got %b exp 0", bus.bus_err); else n_pass++;
    do_io(16'h2077, 1'b0, 16'h0000, 1, 0, 1'b0, 8'h3C);
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_back_to_back();
    test_unmapped();
    test_io_read();
    test_io_timeout();
    test_io_boundary();
    test_random_mem();
    test_random_io();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
